// File: rtl/quad_pkg.sv
// Shared constants and state type for the quad sum-of-squares / square-root datapaths.
package quad_pkg;

  // Sum-of-squares input word: 5 integer + 24 fractional bits
  localparam int C_W    = 29;
  localparam int C_FRAC = 24;

  // Root word: 3 integer + 12 fractional bits
  localparam int R_W    = 15;
  localparam int R_FRAC = 12;

  // Partial remainder width of the restoring digit recurrence
  localparam int REM_W  = 17;

  // Operand shift register: input word plus one guard bit so it pairs up evenly
  localparam int OP_W   = C_W + 1;

  // Iteration counter: one root bit per iteration, counting down to zero
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = 4'(R_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } quad_root_state_e;

endpackage

// File: rtl/quad_root_step.sv
// One restoring square-root iteration: brings down two operand bits and
// decides the next root bit by trial subtraction of {root, 01}.
module quad_root_step
  import quad_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic [R_W-1:0]   i_root,
  input  logic [1:0]       i_bits,
  output logic [REM_W-1:0] o_rem,
  output logic [R_W-1:0]   o_root
);

  // Two bits wider than the remainder so neither the shifted remainder nor
  // the trial value can wrap before the comparison.
  logic [REM_W+1:0] w_t;
  logic [REM_W+1:0] w_trial;
  logic             w_ge;

  assign w_t     = {i_rem, i_bits};
  assign w_trial = {2'b00, i_root, 2'b01};
  assign w_ge    = (w_t >= w_trial);

  // The true remainder never exceeds 2*root, so dropping the top bits after
  // the subtraction loses nothing.
  assign o_rem  = w_ge ? REM_W'(w_t - w_trial) : REM_W'(w_t);
  assign o_root = R_W'({i_root, w_ge});

endmodule

// File: rtl/quad_root.sv
// Sequential fixed-point square root: 5+24 sum-of-squares in, 3+12 magnitude
// out, one root bit per cycle behind valid/ready handshakes on both sides.
module quad_root
  import quad_pkg::*;
#(
  parameter int FWL_C = 24,
  parameter int FWL_R = 12
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [C_W-1:0] i_c,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [R_W-1:0] o_r,
  output logic           o_exact
);

  quad_root_state_e r_state;
  quad_root_state_e w_next_state;

  logic [OP_W-1:0]  r_op;
  logic [REM_W-1:0] r_rem;
  logic [R_W-1:0]   r_root;
  logic [CNT_W-1:0] r_cnt;
  logic [R_W-1:0]   r_r;
  logic             r_exact;

  logic             w_accept;
  logic             w_last;
  logic [C_W-1:0]   w_c_wl;
  logic [REM_W-1:0] w_step_rem;
  logic [R_W-1:0]   w_step_root;
  logic [R_W-1:0]   w_r_trunc;

  // Input word-length truncation: clear the fractional bits beyond FWL_C.
  generate
    if (FWL_C == C_FRAC) begin : g_c_full
      assign w_c_wl = i_c;
    end else begin : g_c_trunc
      assign w_c_wl = {i_c[C_W-1:C_FRAC-FWL_C], {(C_FRAC-FWL_C){1'b0}}};
    end
  endgenerate

  quad_root_step u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_op[OP_W-1 -: 2]),
    .o_rem  (w_step_rem),
    .o_root (w_step_root)
  );

  // Output word-length truncation applied to the final root only, so the
  // exactness flag still reflects the full-precision remainder.
  generate
    if (FWL_R == R_FRAC) begin : g_r_full
      assign w_r_trunc = w_step_root;
    end else begin : g_r_trunc
      assign w_r_trunc = {w_step_root[R_W-1:R_FRAC-FWL_R], {(R_FRAC-FWL_R){1'b0}}};
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the accept / final-iteration strobes for the datapath.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_accept     = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_last       = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: load the operand on accept, iterate during CALC, and latch the
  // result on the final iteration; everything is cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_op    <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_r     <= '0;
      r_exact <= 1'b0;
    end else if (w_accept) begin
      r_op   <= {1'b0, w_c_wl};
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= CNT_INIT;
    end else if (r_state == CALC) begin
      r_op   <= {r_op[OP_W-3:0], 2'b00};
      r_rem  <= w_step_rem;
      r_root <= w_step_root;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_last) begin
        r_r     <= w_r_trunc;
        r_exact <= (w_step_rem == '0);
      end
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_r         = r_r;
  assign o_exact     = r_exact;

endmodule
